// File: rtl/reg_file_pkg.sv
// Shared register-file constants: read-select codes, address width, fixed addresses.
// Latency: none (declarations only).
// Backpressure: not applicable.
package reg_file_pkg;

  localparam int REG_ADDR_W     = 2;
  localparam int DEFAULT_DATA_W = 8;

  // Read-select codes
  localparam logic [1:0] RSEL_R0     = 2'd0;
  localparam logic [1:0] RSEL_FIELD0 = 2'd1;
  localparam logic [1:0] RSEL_FIELD1 = 2'd2;
  localparam logic [1:0] RSEL_R2     = 2'd3;

  // Hard-wired register addresses, shared with the write-address select
  localparam logic [REG_ADDR_W-1:0] FIXED_ADDR_R0 = 2'd0;
  localparam logic [REG_ADDR_W-1:0] FIXED_ADDR_R2 = 2'd2;

endpackage

// File: rtl/reg_file_read_select_read_address_select.sv
// Decodes the read-select code and instruction fields into a register read address.
// Latency: purely combinational.
// Backpressure: none.
module read_address_select
  import reg_file_pkg::*;
(
  input  logic [1:0]            read_select,
  input  logic [REG_ADDR_W-1:0] reg_field0,
  input  logic [REG_ADDR_W-1:0] reg_field1,
  output logic [REG_ADDR_W-1:0] raddr
);

  // Select the address source; any undefined code falls back to register 0
  always_comb begin
    raddr = FIXED_ADDR_R0;
    case (read_select)
      RSEL_R0:     raddr = FIXED_ADDR_R0;
      RSEL_FIELD0: raddr = reg_field0;
      RSEL_FIELD1: raddr = reg_field1;
      RSEL_R2:     raddr = FIXED_ADDR_R2;
      default:     raddr = FIXED_ADDR_R0;
    endcase
  end

endmodule

// File: rtl/reg_file_read_select.sv
// 4-entry register file with decoded read address and synchronous write port.
// Latency: read data and valid strobe one cycle after rd_en.
// Backpressure: none; consumer must take read_data whenever read_valid is high.
// Build option REG_FILE_READ_BYPASS_EN: forward same-cycle write data to a read of
// the same address; otherwise the read returns the old contents (read-before-write).
module reg_file_read_select
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [1:0]            read_select,
  input  logic [REG_ADDR_W-1:0] reg_field0,
  input  logic [REG_ADDR_W-1:0] reg_field1,
  input  logic                  write_en,
  input  logic [REG_ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0]     write_data,
  output logic [DATA_W-1:0]     read_data,
  output logic                  read_valid,
  output logic [REG_ADDR_W-1:0] read_address_q
);

  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     read_data_q;
  logic [DATA_W-1:0]     read_data_d;
  logic                  read_valid_q;
  logic [REG_ADDR_W-1:0] raddr;
  logic [REG_ADDR_W-1:0] raddr_q;

  read_address_select u_read_address_select (
    .read_select (read_select),
    .reg_field0  (reg_field0),
    .reg_field1  (reg_field1),
    .raddr       (raddr)
  );

  // Value captured by a read issued this cycle
`ifdef REG_FILE_READ_BYPASS_EN
  always_comb begin
    read_data_d = regs_q[raddr];
    if (write_en && (write_address == raddr)) begin
      read_data_d = write_data;
    end
  end
`else
  always_comb begin
    read_data_d = regs_q[raddr];
  end
`endif

  // Storage, write port and registered read outputs; reset overrides any request
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      raddr_q      <= '0;
    end else begin
      if (write_en) begin
        regs_q[write_address] <= write_data;
      end
      read_valid_q <= rd_en;
      if (rd_en) begin
        read_data_q <= read_data_d;
        raddr_q     <= raddr;
      end
    end
  end

  assign read_data      = read_data_q;
  assign read_valid     = read_valid_q;
  assign read_address_q = raddr_q;

endmodule

// File: tb/tb_reg_file_read_select.sv
// Directed self-checking bench for reg_file_read_select.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants per scenario.
module tb_reg_file_read_select;

  logic       clk;
  logic       reset;
  logic       rd_en;
  logic [1:0] read_select;
  logic [1:0] reg_field0;
  logic [1:0] reg_field1;
  logic       write_en;
  logic [1:0] write_address;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       read_valid;
  logic [1:0] read_address_q;

  int tests_run;
  int tests_failed;

  reg_file_read_select dut (
    .clk            (clk),
    .reset          (reset),
    .rd_en          (rd_en),
    .read_select    (read_select),
    .reg_field0     (reg_field0),
    .reg_field1     (reg_field1),
    .write_en       (write_en),
    .write_address  (write_address),
    .write_data     (write_data),
    .read_data      (read_data),
    .read_valid     (read_valid),
    .read_address_q (read_address_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus starting at the falling edge, then wait past the rising edge
  task automatic cycle(input logic rst, input logic rd, input logic [1:0] sel,
                       input logic [1:0] f0, input logic [1:0] f1,
                       input logic we, input logic [1:0] wa, input logic [7:0] wd);
    @(negedge clk);
    reset = rst; rd_en = rd; read_select = sel; reg_field0 = f0; reg_field1 = f1;
    write_en = we; write_address = wa; write_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 2'd1, 2'd3, 2'd0, 1'b1, 2'd1, 8'hFF);
    cycle(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_data !== 8'h00 || read_valid !== 1'b0 || read_address_q !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: data=%h valid=%b addr=%0d, want 00/0/0",
               read_data, read_valid, read_address_q);
    end
    // First read in the same cycle reset falls, then walk all registers
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'd1, i[1:0], 2'd0, 1'b0, 2'd0, 8'h00);
      tests_run++;
      if (read_data !== 8'h00 || read_valid !== 1'b1 || read_address_q !== i[1:0]) begin
        tests_failed++;
        $display("FAIL reset_read_r%0d: data=%h valid=%b addr=%0d, want 00/1/%0d",
                 i, read_data, read_valid, read_address_q, i);
      end
    end
    cycle(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid_drop: valid=%b, want 0", read_valid);
    end
  endtask

  task automatic test_decode();
    logic [7:0] vals [4];
    logic [1:0] sel  [4];
    logic [1:0] f0   [4];
    logic [1:0] f1   [4];
    logic [1:0] ea   [4];
    logic [7:0] ed   [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, i[1:0], vals[i]);
    end
    sel = '{2'd0, 2'd3, 2'd2, 2'd1};
    f0  = '{2'd3, 2'd1, 2'd0, 2'd1};
    f1  = '{2'd2, 2'd0, 2'd3, 2'd2};
    ea  = '{2'd0, 2'd2, 2'd3, 2'd1};
    ed  = '{8'h11, 8'h33, 8'h44, 8'h22};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, sel[i], f0[i], f1[i], 1'b0, 2'd0, 8'h00);
      tests_run++;
      if (read_data !== ed[i] || read_valid !== 1'b1 || read_address_q !== ea[i]) begin
        tests_failed++;
        $display("FAIL decode_sel%0d: data=%h valid=%b addr=%0d, want %h/1/%0d",
                 sel[i], read_data, read_valid, read_address_q, ed[i], ea[i]);
      end
    end
    cycle(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed [4];
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'd2, 2'd0, i[1:0], 1'b0, 2'd0, 8'h00);
      tests_run++;
      if (read_data !== ed[i] || read_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_beat%0d: data=%h valid=%b, want %h/1",
                 i, read_data, read_valid, ed[i]);
      end
    end
    cycle(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_valid !== 1'b0 || read_data !== 8'h44) begin
      tests_failed++;
      $display("FAIL stream_end: data=%h valid=%b, want 44/0", read_data, read_valid);
    end
  endtask

  task automatic test_same_cycle_hazard();
    logic [7:0] exp_first;
`ifdef REG_FILE_READ_BYPASS_EN
    exp_first = 8'hA5;
`else
    exp_first = 8'h22;
`endif
    cycle(1'b0, 1'b1, 2'd1, 2'd1, 2'd0, 1'b1, 2'd1, 8'hA5);
    tests_run++;
    if (read_data !== exp_first || read_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hazard_same_cycle: data=%h valid=%b, want %h/1",
               read_data, read_valid, exp_first);
    end
    cycle(1'b0, 1'b1, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL hazard_next_read: data=%h, want a5", read_data);
    end
    // Different addresses in one cycle stay independent
    cycle(1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 2'd0, 8'h5A);
    tests_run++;
    if (read_data !== 8'h33 || read_address_q !== 2'd2) begin
      tests_failed++;
      $display("FAIL diff_addr_read: data=%h addr=%0d, want 33/2", read_data, read_address_q);
    end
    cycle(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL diff_addr_write: data=%h, want 5a", read_data);
    end
  endtask

  task automatic test_reset_priority();
    cycle(1'b1, 1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 2'd2, 8'h7E);
    tests_run++;
    if (read_valid !== 1'b0 || read_data !== 8'h00 || read_address_q !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_priority: data=%h valid=%b addr=%0d, want 00/0/0",
               read_data, read_valid, read_address_q);
    end
    cycle(1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_data !== 8'h00 || read_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_write_dropped: data=%h valid=%b, want 00/1", read_data, read_valid);
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd3, 8'h44);
    cycle(1'b0, 1'b1, 2'd2, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_data !== 8'h44 || read_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_setup: data=%h valid=%b, want 44/1", read_data, read_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 1'b1, 2'd3, 8'h99);
      tests_run++;
      if (read_data !== 8'h44 || read_valid !== 1'b0 || read_address_q !== 2'd3) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: data=%h valid=%b addr=%0d, want 44/0/3",
                 i, read_data, read_valid, read_address_q);
      end
    end
    cycle(1'b0, 1'b1, 2'd1, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00);
    tests_run++;
    if (read_data !== 8'h99) begin
      tests_failed++;
      $display("FAIL hold_write_landed: data=%h, want 99", read_data);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; rd_en = 1'b0; read_select = 2'd0; reg_field0 = 2'd0; reg_field1 = 2'd0;
    write_en = 1'b0; write_address = 2'd0; write_data = 8'h00;
    test_reset();
    test_decode();
    test_back_to_back();
    test_same_cycle_hazard();
    test_reset_priority();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_read_select.md
Name: reg_file_read_select

Overview:
- Read side of the ASIP register file; the counterpart of the write-address select path.
- Decodes a 2-bit read-select code plus two instruction register fields into a read address, then reads the 4-entry register file.
- Returns the data one cycle later with a valid strobe.
- Owns the register storage and its synchronous write port, so that write-after-read ordering and bypass are defined here.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, register count; fixed to 4 because the address is 2 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  1  read request, sampled at the rising edge of clk.
- read_select  in  2  address source: 0 = register 0, 1 = reg_field0, 2 = reg_field1, 3 = register 2.
- reg_field0  in  2  instruction register field 0.
- reg_field1  in  2  instruction register field 1.
- write_en  in  1  register write strobe.
- write_address  in  2  write target, from the write-address select.
- write_data  in  DATA_W  write value.
- read_data  out  DATA_W  registered read result.
- read_valid  out  1  high for one cycle when read_data is updated.
- read_address_q  out  2  registered decoded address, for debug and hazard logic.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset. Everything updates only on the rising edge of clk.
- Reset values:
  - All registers = 0.
  - read_data = 0.
  - read_valid = 0.
  - read_address_q = 0.
- Address decode (combinational): raddr = 0, reg_field0, reg_field1 or 2 for read_select 0..3. Any X or undefined code decodes to 0.
- Read:
  - If rd_en is high at edge N: read_data = regs[raddr], read_address_q = raddr, and read_valid = 1 for cycle N+1. Latency is 1 cycle.
  - If rd_en is low: read_data and read_address_q hold their values, and read_valid = 0.
- Back-to-back reads: rd_en held high gives one result per cycle, with read_valid continuously high.
- Write: if write_en is high at edge N, regs[write_address] = write_data, visible to reads issued at edge N+1 or later.
- Write and read of different addresses in the same cycle: independent.
- Write and read of the same address in the same cycle: bypass behaviour, see Optional Feature.
- Reset asserted together with rd_en or write_en: reset wins. The write is discarded, read_valid = 0, and read_data = 0.
- Reset asserted mid-stream: on the next edge all outputs go to their reset values, and no stale read_valid is produced after reset.
- Reset deasserted: the first read may be issued in the same cycle that reset falls.
- Width rules:
  - No arithmetic in this block.
  - write_data is stored full width.
  - read_data equals the stored value exactly, with no sign or zero extension.
- No stall or backpressure: the consumer must accept read_data whenever read_valid is high.

Optional Feature:
- Macro: REG_FILE_READ_BYPASS_EN.
- Defined: a same-cycle write_en and rd_en with write_address == raddr makes read_data equal write_data (write-through forwarding). The read still has 1-cycle latency.
- Not defined: the same case returns the old register contents, i.e. read-before-write. The new value is seen by the next read.
- All other behaviour is identical with or without the macro.

Decomposition:
- Shared package reg_file_pkg:
  - localparams RSEL_R0 = 2'd0, RSEL_FIELD0 = 2'd1, RSEL_FIELD1 = 2'd2, RSEL_R2 = 2'd3.
  - REG_ADDR_W = 2 and DATA_W default.
  - Constants FIXED_ADDR_R0 = 0 and FIXED_ADDR_R2 = 2, also used by the write-address select.
- One sub-module, read_address_select: a pure combinational decoder mapping (read_select, reg_field0, reg_field1) to raddr.
- The storage array and the output registers stay in the top module.

Test Plan:
- Reset: hold reset for 2 cycles, then read all four registers via read_select=1 with reg_field0 = 0..3 -> read_data = 0x00 each time, read_valid high one cycle after each rd_en.
- Decode: write 0x11, 0x22, 0x33, 0x44 to regs 0..3; read_select=0 -> 0x11; read_select=3 -> 0x33; read_select=2 with reg_field1=3 -> 0x44; read_select=1 with reg_field0=1 -> 0x22.
- Latency and streaming: rd_en high for 4 consecutive cycles on regs 0,1,2,3 -> read_valid high for exactly 4 cycles starting one cycle later, data 0x11, 0x22, 0x33, 0x44 in order.
- Same-cycle hazard: reg1 = 0x22; write 0xA5 to reg1 while reading reg1 -> 0xA5 with REG_FILE_READ_BYPASS_EN, 0x22 without; the following read -> 0xA5 in both builds.
- Reset priority: assert reset in the same cycle as write_en (reg2 <= 0x7E) and rd_en -> next cycle read_valid = 0 and read_data = 0x00; a later read of reg2 -> 0x00.
- Hold: after a read returns 0x44, keep rd_en low for 3 cycles while writing reg3 = 0x99 -> read_data stays 0x44 and read_valid stays 0.
